// File: rtl/alu8_pkg.sv
// Shared widths, alu8 opcode map and result payload for the alu8 issue engine.
package alu8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] OP_ADD   = 4'd0;
  localparam logic [SEL_W-1:0] OP_SUB   = 4'd1;
  localparam logic [SEL_W-1:0] OP_AND   = 4'd2;
  localparam logic [SEL_W-1:0] OP_OR    = 4'd3;
  localparam logic [SEL_W-1:0] OP_XOR   = 4'd4;
  localparam logic [SEL_W-1:0] OP_NOT   = 4'd5;
  localparam logic [SEL_W-1:0] OP_SHL   = 4'd6;
  localparam logic [SEL_W-1:0] OP_SHR   = 4'd7;
  localparam logic [SEL_W-1:0] OP_INC   = 4'd8;
  localparam logic [SEL_W-1:0] OP_DEC   = 4'd9;
  localparam logic [SEL_W-1:0] OP_PASSA = 4'd10;
  localparam logic [SEL_W-1:0] OP_PASSB = 4'd11;

  // alu8 result word; the sequence tag travels beside it in the FIFO
  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              z;
    logic              c;
    logic              n;
  } alu_res_t;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; C is carry for add/inc, borrow for sub/dec, shifted-out bit for shifts.
module alu8
  import alu8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] y,
  output logic              z,
  output logic              c,
  output logic              n
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    unique case (sel)
      OP_ADD:   wide = {1'b0, a} + {1'b0, b};
      OP_SUB:   wide = {1'b0, a} - {1'b0, b};
      OP_AND:   wide = {1'b0, a & b};
      OP_OR:    wide = {1'b0, a | b};
      OP_XOR:   wide = {1'b0, a ^ b};
      OP_NOT:   wide = {1'b0, ~a};
      OP_SHL:   wide = {a, 1'b0};
      OP_SHR:   wide = {a[0], 1'b0, a[DATA_W-1:1]};
      OP_INC:   wide = {1'b0, a} + 9'd1;
      OP_DEC:   wide = {1'b0, a} - 9'd1;
      OP_PASSA: wide = {1'b0, a};
      OP_PASSB: wide = {1'b0, b};
      default:  wide = '0;
    endcase
  end

  assign y = wide[DATA_W-1:0];
  assign c = wide[DATA_W];
  assign z = (wide[DATA_W-1:0] == '0);
  assign n = wide[DATA_W-1];

endmodule

// File: rtl/alu8_res_fifo.sv
// Shift-register result FIFO; entry 0 is the head and keeps its last value once the FIFO empties.
module alu8_res_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          not_empty
);

  logic [W-1:0]  mem   [DEPTH];
  logic [W-1:0]  mem_n [DEPTH];
  logic          pop_ok_c;
  logic [CW-1:0] wr_idx_c;
  logic [CW-1:0] count_n;

  assign pop_ok_c = pop && (count != '0);
  assign wr_idx_c = count - CW'(pop_ok_c);
  assign count_n  = count + CW'(push) - CW'(pop_ok_c);

  // Shift only when a successor exists so the head holds after the last pop
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_n[i] = mem[i];
    if (pop_ok_c && (count > CW'(1))) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i + 1];
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx_c) mem_n[i] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      count     <= count_n;
      not_empty <= (count_n != '0);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/alu8_issue_engine.sv
// Issues requests to alu8 from a registered operand stage and returns tagged results through a FIFO.
module alu8_issue_engine
  import alu8_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic              out_z,
  output logic              out_c,
  output logic              out_n,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] acc,
  output logic [15:0]       op_count
);

  localparam int unsigned RES_W = $bits(alu_res_t);
  localparam int unsigned FW    = RES_W + TAG_W;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = CW + 1;

  logic              stage_valid;
  logic [DATA_W-1:0] stage_a;
  logic [DATA_W-1:0] stage_b;
  logic [SEL_W-1:0]  stage_sel;
  logic [TAG_W-1:0]  stage_tag;
  logic [TAG_W-1:0]  tag_q;

  logic [DATA_W-1:0] alu_y;
  logic              alu_z;
  logic              alu_c;
  logic              alu_n;

  logic              accept_c;
  logic              pop_c;
  logic [DATA_W-1:0] opa_c;
  logic [OW-1:0]     occ_nxt_c;
  logic [CW-1:0]     fifo_count;
  logic              fifo_valid;
  alu_res_t          push_res;
  alu_res_t          head_res;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_head;

  assign accept_c = in_valid && in_ready;
  assign pop_c    = fifo_valid && out_ready;

  // Forward the in-flight result so back-to-back chaining sees the fresh Y
  assign opa_c = !in_acc ? in_a : (stage_valid ? alu_y : acc);

  // Occupancy after this edge; registering its compare keeps out_ready off the in_ready path
  assign occ_nxt_c = OW'(fifo_count) + OW'(stage_valid) - OW'(pop_c) + OW'(accept_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_a     <= '0;
      stage_b     <= '0;
      stage_sel   <= '0;
      stage_tag   <= '0;
      tag_q       <= '0;
      acc         <= '0;
      op_count    <= '0;
      in_ready    <= 1'b1;
    end else begin
      stage_valid <= accept_c;
      if (accept_c) begin
        stage_a   <= opa_c;
        stage_b   <= in_b;
        stage_sel <= in_sel;
        stage_tag <= tag_q;
        tag_q     <= tag_q + TAG_W'(1);
      end
      if (stage_valid) acc <= alu_y;
      if (pop_c && (op_count != 16'hFFFF)) op_count <= op_count + 16'd1;
      in_ready <= (occ_nxt_c < OW'(DEPTH));
    end
  end

  alu8 u_alu8 (
    .a   (stage_a),
    .b   (stage_b),
    .sel (stage_sel),
    .y   (alu_y),
    .z   (alu_z),
    .c   (alu_c),
    .n   (alu_n)
  );

  assign push_res = '{y: alu_y, z: alu_z, c: alu_c, n: alu_n};
  assign fifo_din = {stage_tag, push_res};

  alu8_res_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stage_valid),
    .din       (fifo_din),
    .pop       (pop_c),
    .head      (fifo_head),
    .count     (fifo_count),
    .not_empty (fifo_valid)
  );

  assign {out_tag, head_res} = fifo_head;
  assign out_y     = head_res.y;
  assign out_z     = head_res.z;
  assign out_c     = head_res.c;
  assign out_n     = head_res.n;
  assign out_valid = fifo_valid;

endmodule
